prog_sequencer: RTL and testbench



---
 rtl/prog_sequencer_if.sv | 29 ++
 rtl/prog_sequencer.sv | 135 +++++++++++++
 tb/tb_prog_sequencer.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/prog_sequencer_if.sv
// Fetch-control bundle between prog_sequencer (master) and its environment (slave).
// The master drives the fetch-unit controls and the status flags.
interface prog_sequencer_if #(
  parameter int PC_W = 10
);
  logic            Start;
  logic            Halt;
  logic            BrTaken;
  logic            BrRel;
  logic [PC_W-1:0] BrTarget;
  logic            Hold;
  logic            Jump;
  logic            BranchAbsOrRel;
  logic [PC_W-1:0] Target;
  logic [1:0]      ProgSel;
  logic            Busy;
  logic            Ack;
  logic            Timeout;

  modport master (
    input  Start, Halt, BrTaken, BrRel, BrTarget,
    output Hold, Jump, BranchAbsOrRel, Target, ProgSel, Busy, Ack, Timeout
  );

  modport slave (
    output Start, Halt, BrTaken, BrRel, BrTarget,
    input  Hold, Jump, BranchAbsOrRel, Target, ProgSel, Busy, Ack, Timeout
  );
endinterface

// File: rtl/prog_sequencer.sv
// Program-level fetch controller: loads each program's base, passes branches, freezes on halt.
// Optional RUN watchdog enabled by defining PROG_TIMEOUT_EN.
module prog_sequencer #(
  parameter int                PC_W        = 10,
  parameter int                NUM_PROGS   = 3,
  parameter logic [4*PC_W-1:0] BASE_TABLE  = {10'd768, 10'd512, 10'd256, 10'd0},
  parameter int                TIMEOUT_CYC = 1023
) (
  input logic              Clk,
  input logic              Reset,
  prog_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      prog_sel_q, prog_sel_d;
  logic            hold, jump, abs_or_rel;
  logic [PC_W-1:0] target;
  logic [PC_W-1:0] base_sel;

`ifdef PROG_TIMEOUT_EN
  logic [PC_W-1:0] cnt_q, cnt_d;
  logic            timeout_q, timeout_d;
`endif

  always_comb begin
    case (prog_sel_q)
      2'd0:    base_sel = BASE_TABLE[0*PC_W +: PC_W];
      2'd1:    base_sel = BASE_TABLE[1*PC_W +: PC_W];
      2'd2:    base_sel = BASE_TABLE[2*PC_W +: PC_W];
      default: base_sel = BASE_TABLE[3*PC_W +: PC_W];
    endcase
  end

  always_comb begin
    state_d    = state_q;
    prog_sel_d = prog_sel_q;
    hold       = 1'b1;
    jump       = 1'b0;
    abs_or_rel = 1'b0;
    target     = '0;
`ifdef PROG_TIMEOUT_EN
    cnt_d      = cnt_q;
    timeout_d  = timeout_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.Start) begin
          state_d = S_LOAD;
`ifdef PROG_TIMEOUT_EN
          cnt_d     = '0;
          timeout_d = 1'b0;
`endif
        end
      end
      S_LOAD: begin
        hold   = 1'b0;
        jump   = 1'b1;
        target = base_sel;
        if (!bus.Start) state_d = S_RUN;
      end
      S_RUN: begin
        // Halt wins over a same-cycle branch so the PC parks on the halt instruction.
        hold       = bus.Halt;
        jump       = bus.BrTaken & ~bus.Halt;
        abs_or_rel = bus.BrRel;
        target     = bus.BrTarget;
        if (bus.Halt) begin
          state_d = S_DONE;
        end
`ifdef PROG_TIMEOUT_EN
        else begin
          // cnt_d counts RUN cycles including this one; trips in the TIMEOUT_CYC-th.
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == PC_W'(TIMEOUT_CYC)) begin
            state_d   = S_DONE;
            timeout_d = 1'b1;
            hold      = 1'b1;
            jump      = 1'b0;
          end
        end
`endif
      end
      S_DONE: begin
        if (bus.Start) begin
          state_d    = S_LOAD;
          prog_sel_d = (prog_sel_q == 2'(NUM_PROGS - 1)) ? 2'd0 : prog_sel_q + 2'd1;
`ifdef PROG_TIMEOUT_EN
          cnt_d      = '0;
          timeout_d  = 1'b0;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      prog_sel_q <= 2'd0;
`ifdef PROG_TIMEOUT_EN
      cnt_q      <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      prog_sel_q <= prog_sel_d;
`ifdef PROG_TIMEOUT_EN
      cnt_q      <= cnt_d;
      timeout_q  <= timeout_d;
`endif
    end
  end

  assign bus.Hold           = hold;
  assign bus.Jump           = jump;
  assign bus.BranchAbsOrRel = abs_or_rel;
  assign bus.Target         = target;
  assign bus.ProgSel        = prog_sel_q;
  assign bus.Busy           = (state_q == S_LOAD) || (state_q == S_RUN);
  assign bus.Ack            = (state_q == S_DONE);
`ifdef PROG_TIMEOUT_EN
  assign bus.Timeout        = timeout_q;
`else
  assign bus.Timeout        = 1'b0;
`endif

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed bench for prog_sequencer with a reference fetch-unit PC model.
// Per-cycle vector table plus hand-written reset, 1-cycle Start and watchdog sequences.
module tb_prog_sequencer;

  localparam int PC_W   = 10;
  localparam int TO_CYC = 32;
  localparam int NVEC   = 28;

  typedef struct {
    logic            start;
    logic            halt;
    logic            br_taken;
    logic            br_rel;
    logic [PC_W-1:0] br_target;
    logic            exp_hold;
    logic            exp_jump;
    logic            exp_rel;
    logic [PC_W-1:0] exp_target;
    logic            exp_ack;
    logic            exp_busy;
    logic [1:0]      exp_sel;
    logic [PC_W-1:0] exp_pc;
  } vec_t;

  logic            Clk;
  logic            Reset;
  logic [PC_W-1:0] pc;
  int              errors;
  int              checks;
  vec_t            vecs[NVEC];

  prog_sequencer_if #(.PC_W(PC_W)) bus ();

  prog_sequencer #(
    .PC_W       (PC_W),
    .NUM_PROGS  (3),
    .BASE_TABLE ({10'd768, 10'd512, 10'd256, 10'd0}),
    .TIMEOUT_CYC(TO_CYC)
  ) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference fetch unit: reset to a non-base value so the first LOAD is visible.
  always @(posedge Clk) begin
    if (Reset)
      pc <= 10'd7;
    else if (!bus.Hold)
      pc <= bus.Jump ? (bus.BranchAbsOrRel ? pc + bus.Target : bus.Target) : pc + 10'd1;
  end

  function automatic vec_t v(input logic s, h, bt, br, input logic [PC_W-1:0] btg,
                             input logic eh, ej, er, input logic [PC_W-1:0] et,
                             input logic ea, eb, input logic [1:0] es,
                             input logic [PC_W-1:0] ep);
    vec_t r;
    r.start = s; r.halt = h; r.br_taken = bt; r.br_rel = br; r.br_target = btg;
    r.exp_hold = eh; r.exp_jump = ej; r.exp_rel = er; r.exp_target = et;
    r.exp_ack = ea; r.exp_busy = eb; r.exp_sel = es; r.exp_pc = ep;
    return r;
  endfunction

  task automatic checkOutput(input string name, input int unsigned actual,
                             input int unsigned expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Drive one cycle's inputs on the falling edge, then compare a little later.
  task automatic applyStimulus(input vec_t t, input string tag);
    @(negedge Clk);
    bus.Start    = t.start;
    bus.Halt     = t.halt;
    bus.BrTaken  = t.br_taken;
    bus.BrRel    = t.br_rel;
    bus.BrTarget = t.br_target;
    #2;
    checkOutput({tag, ".hold"},   bus.Hold,           t.exp_hold);
    checkOutput({tag, ".jump"},   bus.Jump,           t.exp_jump);
    checkOutput({tag, ".rel"},    bus.BranchAbsOrRel, t.exp_rel);
    checkOutput({tag, ".target"}, bus.Target,         t.exp_target);
    checkOutput({tag, ".ack"},    bus.Ack,            t.exp_ack);
    checkOutput({tag, ".busy"},   bus.Busy,           t.exp_busy);
    checkOutput({tag, ".sel"},    bus.ProgSel,        t.exp_sel);
    checkOutput({tag, ".pc"},     pc,                 t.exp_pc);
  endtask

  initial begin
    errors       = 0;
    checks       = 0;
    Reset        = 1'b1;
    bus.Start    = 1'b0;
    bus.Halt     = 1'b0;
    bus.BrTaken  = 1'b0;
    bus.BrRel    = 1'b0;
    bus.BrTarget = '0;

    //            s  h  bt br btg     hd jp rl tgt     ak by sl pc
    vecs[0]  = v(0, 0, 0, 0, 0,      1, 0, 0, 0,     0, 0, 0, 7);
    vecs[1]  = v(1, 0, 0, 0, 0,      1, 0, 0, 0,     0, 0, 0, 7);
    vecs[2]  = v(1, 0, 0, 0, 0,      0, 1, 0, 0,     0, 1, 0, 7);
    vecs[3]  = v(1, 0, 0, 0, 0,      0, 1, 0, 0,     0, 1, 0, 0);
    vecs[4]  = v(0, 0, 0, 0, 0,      0, 1, 0, 0,     0, 1, 0, 0);
    vecs[5]  = v(0, 0, 0, 0, 0,      0, 0, 0, 0,     0, 1, 0, 0);
    vecs[6]  = v(0, 0, 0, 0, 0,      0, 0, 0, 0,     0, 1, 0, 1);
    vecs[7]  = v(0, 0, 0, 0, 0,      0, 0, 0, 0,     0, 1, 0, 2);
    vecs[8]  = v(0, 0, 0, 0, 0,      0, 0, 0, 0,     0, 1, 0, 3);
    vecs[9]  = v(0, 0, 0, 0, 0,      0, 0, 0, 0,     0, 1, 0, 4);
    vecs[10] = v(0, 0, 1, 1, 'h3FE,  0, 1, 1, 'h3FE, 0, 1, 0, 5);
    vecs[11] = v(0, 0, 1, 0, 40,     0, 1, 0, 40,    0, 1, 0, 3);
    vecs[12] = v(0, 0, 1, 0, 11,     0, 1, 0, 11,    0, 1, 0, 40);
    vecs[13] = v(0, 0, 0, 0, 0,      0, 0, 0, 0,     0, 1, 0, 11);
    vecs[14] = v(0, 1, 1, 0, 99,     1, 0, 0, 99,    0, 1, 0, 12);
    vecs[15] = v(0, 0, 0, 0, 0,      1, 0, 0, 0,     1, 0, 0, 12);
    vecs[16] = v(0, 1, 1, 1, 5,      1, 0, 0, 0,     1, 0, 0, 12);
    vecs[17] = v(1, 0, 0, 0, 0,      1, 0, 0, 0,     1, 0, 0, 12);
    vecs[18] = v(0, 0, 0, 0, 0,      0, 1, 0, 256,   0, 1, 1, 12);
    vecs[19] = v(1, 0, 0, 0, 0,      0, 0, 0, 0,     0, 1, 1, 256);
    vecs[20] = v(0, 1, 0, 0, 0,      1, 0, 0, 0,     0, 1, 1, 257);
    vecs[21] = v(1, 0, 0, 0, 0,      1, 0, 0, 0,     1, 0, 1, 257);
    vecs[22] = v(0, 0, 0, 0, 0,      0, 1, 0, 512,   0, 1, 2, 257);
    vecs[23] = v(0, 1, 0, 0, 0,      1, 0, 0, 0,     0, 1, 2, 512);
    vecs[24] = v(1, 0, 0, 0, 0,      1, 0, 0, 0,     1, 0, 2, 512);
    vecs[25] = v(0, 0, 0, 0, 0,      0, 1, 0, 0,     0, 1, 0, 512);
    vecs[26] = v(0, 1, 0, 0, 0,      1, 0, 0, 0,     0, 1, 0, 0);
    vecs[27] = v(0, 0, 0, 0, 0,      1, 0, 0, 0,     1, 0, 0, 0);

    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;

    $display("[TB] vector table: load, branches, halt priority, program wrap");
    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i], $sformatf("v%0d", i));
      checkOutput($sformatf("v%0d.timeout", i), bus.Timeout, 0);
    end

    $display("[TB] reset in RUN with ProgSel=2");
    applyStimulus(v(1, 0, 0, 0, 0,  1, 0, 0, 0,    1, 0, 0, 0),   "r0");
    applyStimulus(v(0, 0, 0, 0, 0,  0, 1, 0, 256,  0, 1, 1, 0),   "r1");
    applyStimulus(v(0, 1, 0, 0, 0,  1, 0, 0, 0,    0, 1, 1, 256), "r2");
    applyStimulus(v(1, 0, 0, 0, 0,  1, 0, 0, 0,    1, 0, 1, 256), "r3");
    applyStimulus(v(0, 0, 0, 0, 0,  0, 1, 0, 512,  0, 1, 2, 256), "r4");
    applyStimulus(v(0, 0, 0, 0, 0,  0, 0, 0, 0,    0, 1, 2, 512), "r5");
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    #2;
    checkOutput("rst.hold", bus.Hold,    1);
    checkOutput("rst.jump", bus.Jump,    0);
    checkOutput("rst.ack",  bus.Ack,     0);
    checkOutput("rst.busy", bus.Busy,    0);
    checkOutput("rst.sel",  bus.ProgSel, 0);

    $display("[TB] single-cycle Start gives one LOAD cycle");
    applyStimulus(v(1, 0, 0, 0, 0,  1, 0, 0, 0,  0, 0, 0, 7), "p0");
    applyStimulus(v(0, 0, 0, 0, 0,  0, 1, 0, 0,  0, 1, 0, 7), "p1");
    applyStimulus(v(0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 1, 0, 0), "p2");
    applyStimulus(v(0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 1, 0, 1), "p3");

`ifdef PROG_TIMEOUT_EN
    $display("[TB] watchdog trips after TO_CYC RUN cycles");
    applyStimulus(v(0, 1, 0, 0, 0,  1, 0, 0, 0,    0, 1, 0, 2),   "t0");
    applyStimulus(v(1, 0, 0, 0, 0,  1, 0, 0, 0,    1, 0, 0, 2),   "t1");
    applyStimulus(v(0, 0, 0, 0, 0,  0, 1, 0, 256,  0, 1, 1, 2),   "t2");
    for (int k = 1; k < TO_CYC; k++)
      applyStimulus(v(0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 1, 1, PC_W'(256 + k - 1)),
                    $sformatf("t_run%0d", k));
    applyStimulus(v(0, 0, 0, 0, 0,  1, 0, 0, 0,  0, 1, 1, PC_W'(256 + TO_CYC - 1)), "t_trip");
    checkOutput("t_trip.timeout", bus.Timeout, 0);
    applyStimulus(v(1, 0, 0, 0, 0,  1, 0, 0, 0,  1, 0, 1, PC_W'(256 + TO_CYC - 1)), "t_done");
    checkOutput("t_done.timeout", bus.Timeout, 1);
    applyStimulus(v(0, 0, 0, 0, 0,  0, 1, 0, 512,  0, 1, 2, PC_W'(256 + TO_CYC - 1)), "t_load");
    checkOutput("t_load.timeout", bus.Timeout, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
